// File: rtl/register_bus_arbiter.sv
// Round-robin arbiter that shares one register bus between two requesters.
// One transaction in flight; read data is routed back only to the issuing port.
module register_bus_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic        ipReq0,
  input  logic        ipReq1,
  input  logic        ipWrEn0,
  input  logic        ipWrEn1,
  input  logic [7:0]  ipAddr0,
  input  logic [7:0]  ipAddr1,
  input  logic [31:0] ipWrData0,
  input  logic [31:0] ipWrData1,
  output logic        opAck0,
  output logic        opAck1,
  output logic        opRdValid0,
  output logic        opRdValid1,
  output logic [31:0] opRdData0,
  output logic [31:0] opRdData1,
  output logic [7:0]  opAddress,
  output logic [31:0] opWrData,
  output logic        opWrEnable,
  input  logic [31:0] ipRdData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wren_q, wren_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        rv0_q, rv0_d;
  logic        rv1_q, rv1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        grant;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    wren_d       = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rv0_d        = 1'b0;
    rv1_d        = 1'b0;
    grant        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ipReq0 || ipReq1) begin
          // On a tie the port that did not win last time is served.
          grant        = (ipReq0 && ipReq1) ? ~last_grant_q : ipReq1;
          last_grant_d = grant;
          addr_d       = grant ? ipAddr1   : ipAddr0;
          wdata_d      = grant ? ipWrData1 : ipWrData0;
          wren_d       = grant ? ipWrEn1   : ipWrEn0;
          ack0_d       = ~grant;
          ack1_d       = grant;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (wren_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = 3'(READ_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          if (last_grant_q) begin
            rdata1_d = ipRdData;
            rv1_d    = 1'b1;
          end else begin
            rdata0_d = ipRdData;
            rv0_d    = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ipClk) begin
    // NOTE: reset is sampled on the clock edge; all state, including captured read data, returns to known values.
    if (ipReset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 3'd0;
      addr_q       <= 8'd0;
      wdata_q      <= 32'd0;
      wren_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rv0_q        <= 1'b0;
      rv1_q        <= 1'b0;
      rdata0_q     <= 32'd0;
      rdata1_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wren_q       <= wren_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rv0_q        <= rv0_d;
      rv1_q        <= rv1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign opAck0     = ack0_q;
  assign opAck1     = ack1_q;
  assign opRdValid0 = rv0_q;
  assign opRdValid1 = rv1_q;
  assign opRdData0  = rdata0_q;
  assign opRdData1  = rdata1_q;
  assign opAddress  = addr_q;
  assign opWrData   = wdata_q;
  assign opWrEnable = wren_q;

endmodule
